fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Parametrised next-generation programme counter and fetch-address generator for the rv32i core.
- Drives instruction-memory fetch requests over a valid/ready handshake, holding the address stable until it is accepted.
- Supports prioritised redirects (trap > branch), buffers redirects that arrive while a request is outstanding, and detects misaligned targets.
- Supports halt/resume, a configurable reset vector, configurable XLEN and configurable instruction length.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 0, fetch address loaded on reset (XLEN bits).
- ILEN_BYTES, 4, sequential increment in bytes; must be 2 or 4.
- ALIGN_BITS, derived as log2(ILEN_BYTES); local, not overridable.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  instruction memory accepts request
- imem_req_addr  out  XLEN  fetch address (the internal pc register)
- stall  in  1  suppresses new request issue
- branch_en  in  1  single-cycle branch/jump redirect pulse
- branch_target  in  XLEN  branch destination
- trap_en  in  1  single-cycle trap redirect pulse
- trap_target  in  XLEN  trap vector
- halt_req  in  1  request to stop fetching
- resume  in  1  single-cycle pulse leaving HALT
- pc_current  out  XLEN  address of last accepted fetch
- pc_next  out  XLEN  pc_current + ILEN_BYTES (combinational)
- misaligned_err  out  1  one-cycle pulse on misaligned branch target
- misaligned_addr  out  XLEN  offending target, held until next error

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - When rstn=0 at a clock edge: pc=RESET_VECTOR, pc_current=RESET_VECTOR, state=BOOT, pending cleared, held=0, misaligned_err=0, misaligned_addr=0.
  - Reset mid-transaction abandons the outstanding request without waiting for ready.
- States:
  - BOOT: valid=0. Always goes to RUN next cycle. Redirects arriving in BOOT are ignored.
  - RUN: normal fetch operation.
  - HALT: valid=0. Leaves on resume (pc unchanged) or on trap_en (pc=trap target). Branches are ignored.
  - ERR: valid=0. Leaves only on trap_en (pc=trap target). Branches and resume are ignored.
- Request valid and handshake:
  - imem_req_valid = (state==RUN) && (held || !stall).
  - fire = valid && ready.
  - held is set when valid && !ready and cleared on fire. Once asserted, valid and addr must stay stable until fire, regardless of stall.
- Redirect priority, highest first: new trap, pending trap, new branch, pending branch.
  - The selected target is applied when !held || fire.
  - Otherwise the new redirect is stored in the single pending slot. A trap overwrites a pending branch; a branch never overwrites a pending trap.
- PC update in RUN on fire:
  - pc_current <= addr.
  - pc <= redirect target if one is selected, else pc + ILEN_BYTES.
  - Pending slot clears when its target is used.
- PC update in RUN without fire:
  - With no outstanding request, a redirect loads pc immediately.
  - Otherwise pc holds.
- Arithmetic: modulo 2^XLEN, so XLEN=32, ILEN=4: 0xFFFFFFFC -> 0x00000000. No overflow flag.
- Misaligned branch (target[ALIGN_BITS-1:0] != 0):
  - Target is not loaded.
  - misaligned_err pulses in the cycle the target would have been applied; misaligned_addr latches the target.
  - State goes to ERR; pc holds.
- Trap targets are never flagged; their low ALIGN_BITS are forced to 0.
- Halt: halt_req in RUN enters HALT at the first edge where held=0, i.e. after any outstanding request fires. A redirect selected on that same edge is still applied to pc before halting.
- Simultaneous events:
  - trap_en and branch_en together: trap wins, branch discarded.
  - trap_en and halt_req together: trap applied, then HALT.
  - resume and trap_en in HALT: trap target used.

Test Plan:
- Reset with RESET_VECTOR=0x80: BOOT one cycle, then valid=1, addr=0x80. With ready=1 every cycle, addr steps 0x84, 0x88; pc_current lags addr by one cycle.
- ready=0 for 3 cycles with addr=0x90, branch_en to 0x200 in cycle 1, stall=1 asserted: valid and addr stay 0x90. On fire, next addr=0x200 (not 0x94).
- Outstanding request: branch to 0x300, then trap to 0x40 one cycle later, then branch to 0x500. After fire, addr=0x40.
- Branch target 0x102 (ILEN_BYTES=4): misaligned_err pulses once, misaligned_addr=0x102, valid drops. trap_en with 0x1C1 -> addr=0x1C0, RUN resumes.
- Wrap-around: force pc=0xFFFFFFFC and fire -> addr=0x00000000.
- halt_req during an outstanding request: valid held until ready, then HALT with valid=0. resume -> fetch continues at pc+4. Reset asserted mid-HALT returns to RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: programme counter and instruction-fetch request generator
module fetch_pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              ILEN_BYTES   = 4
) (
   input  logic            clk,
   input  logic            rstn,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            stall,
   input  logic            branch_en,
   input  logic [XLEN-1:0] branch_target,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_target,
   input  logic            halt_req,
   input  logic            resume,
   output logic [XLEN-1:0] pc_current,
   output logic [XLEN-1:0] pc_next,
   output logic            misaligned_err,
   output logic [XLEN-1:0] misaligned_addr
);
   localparam int              ALIGN_BITS = $clog2(ILEN_BYTES);
   localparam logic [XLEN-1:0] INC        = XLEN'(ILEN_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(ILEN_BYTES - 1);
   typedef enum logic [1:0] {BOOT, RUN, HALT, ERR} state_t;
   state_t          state;
   logic [XLEN-1:0] pc;
   logic            held;
   logic            pend_v;
   logic            pend_trap;
   logic [XLEN-1:0] pend_tgt;
   logic            fire;
   logic            apply;
   logic            sel_en;
   logic            sel_trap;
   logic [XLEN-1:0] sel_tgt;
   logic            mis;
   assign imem_req_valid = (state == RUN) && (held || !stall);
   assign imem_req_addr  = pc;
   assign pc_next        = pc_current + INC;
   assign fire           = imem_req_valid && imem_req_ready;
   // a presented address may only change once accepted, so redirects land on fire or when nothing is presented
   assign apply          = fire || !imem_req_valid;
   // redirect selection: new trap > pending trap > new branch > pending branch
   always_comb begin
      sel_en   = trap_en || pend_v || branch_en;
      sel_trap = trap_en || (pend_v && pend_trap);
      sel_tgt  = trap_en ? trap_target :
                 (pend_v && pend_trap) ? pend_tgt :
                 branch_en ? branch_target : pend_tgt;
      mis      = sel_en && !sel_trap && (sel_tgt[ALIGN_BITS-1:0] != '0);
   end
   // fetch state machine, pc, pending redirect slot and misalignment reporting
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state           <= BOOT;
         pc              <= RESET_VECTOR;
         pc_current      <= RESET_VECTOR;
         held            <= 1'b0;
         pend_v          <= 1'b0;
         pend_trap       <= 1'b0;
         pend_tgt        <= '0;
         misaligned_err  <= 1'b0;
         misaligned_addr <= '0;
      end else begin
         misaligned_err <= 1'b0;
         case (state)
            BOOT: state <= RUN;
            RUN: begin
               held <= imem_req_valid && !imem_req_ready;
               if (fire) pc_current <= pc;
               if (apply) begin
                  pend_v <= 1'b0;
                  if (mis) begin
                     misaligned_err  <= 1'b1;
                     misaligned_addr <= sel_tgt;
                     state           <= ERR;
                  end else begin
                     if (sel_en) pc <= sel_tgt & ALIGN_MASK;
                     else if (fire) pc <= pc + INC;
                     if (halt_req) state <= HALT;
                  end
               end else if (trap_en) begin
                  pend_v    <= 1'b1;
                  pend_trap <= 1'b1;
                  pend_tgt  <= trap_target;
               end else if (branch_en && !(pend_v && pend_trap)) begin
                  pend_v    <= 1'b1;
                  pend_trap <= 1'b0;
                  pend_tgt  <= branch_target;
               end
            end
            HALT: begin
               if (trap_en) pc <= trap_target & ALIGN_MASK;
               if (trap_en || resume) state <= RUN;
            end
            default: begin
               if (trap_en) pc <= trap_target & ALIGN_MASK;
               if (trap_en) state <= RUN;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven check of fetch_pc_unit with RESET_VECTOR=0x80
module tb_fetch_pc_unit;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        stall = 1'b0;
   logic        branch_en = 1'b0;
   logic [31:0] branch_target = '0;
   logic        trap_en = 1'b0;
   logic [31:0] trap_target = '0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic [31:0] pc_current;
   logic [31:0] pc_next;
   logic        misaligned_err;
   logic [31:0] misaligned_addr;
   int          n_chk = 0;
   int          n_fail = 0;
   typedef struct {
      logic [31:0] st, rd, be, bt, te, tt, hr, rs, ev, ea, ec, ee, em;
   } vec_t;
   vec_t q[$];

   fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h80), .ILEN_BYTES(4)) dut (
      .clk(clk), .rstn(rstn),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
      .trap_en(trap_en), .trap_target(trap_target), .halt_req(halt_req), .resume(resume),
      .pc_current(pc_current), .pc_next(pc_next),
      .misaligned_err(misaligned_err), .misaligned_addr(misaligned_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int r, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL row %0d %s: got %h expected %h", r, n, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] st, rd, be, bt, te, tt, hr, rs, ev, ea, ec, ee, em);
      vec_t v;
      v.st = st; v.rd = rd; v.be = be; v.bt = bt; v.te = te; v.tt = tt; v.hr = hr; v.rs = rs;
      v.ev = ev; v.ea = ea; v.ec = ec; v.ee = ee; v.em = em;
      q.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      stall = v.st[0]; imem_req_ready = v.rd[0];
      branch_en = v.be[0]; branch_target = v.bt;
      trap_en = v.te[0]; trap_target = v.tt;
      halt_req = v.hr[0]; resume = v.rs[0];
   endtask

   initial begin
      //  st rd be bt          te tt          hr rs   ev ea          ec          ee em
      add(0, 1, 1, 'h400,      0, 0,          0, 0,   0, 'h80,       'h80,       0, 0);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h80,       'h80,       0, 0);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h84,       'h80,       0, 0);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h88,       'h84,       0, 0);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h8C,       'h88,       0, 0);
      add(0, 0, 0, 0,          0, 0,          0, 0,   1, 'h90,       'h8C,       0, 0);
      add(1, 0, 1, 'h200,      0, 0,          0, 0,   1, 'h90,       'h8C,       0, 0);
      add(1, 0, 0, 0,          0, 0,          0, 0,   1, 'h90,       'h8C,       0, 0);
      add(1, 1, 0, 0,          0, 0,          0, 0,   1, 'h90,       'h8C,       0, 0);
      add(0, 0, 0, 0,          0, 0,          0, 0,   1, 'h200,      'h90,       0, 0);
      add(0, 0, 1, 'h300,      0, 0,          0, 0,   1, 'h200,      'h90,       0, 0);
      add(0, 0, 0, 0,          1, 'h40,       0, 0,   1, 'h200,      'h90,       0, 0);
      add(0, 0, 1, 'h500,      0, 0,          0, 0,   1, 'h200,      'h90,       0, 0);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h200,      'h90,       0, 0);
      add(0, 1, 1, 'h102,      0, 0,          0, 0,   1, 'h40,       'h200,      0, 0);
      add(0, 1, 1, 'h800,      0, 0,          0, 1,   0, 'h40,       'h40,       1, 'h102);
      add(0, 1, 0, 0,          1, 'h1C1,      0, 0,   0, 'h40,       'h40,       0, 'h102);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h1C0,      'h40,       0, 'h102);
      add(1, 0, 1, 'h600,      1, 'hFFFFFFFE, 0, 0,   0, 'h1C4,      'h1C0,      0, 'h102);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'hFFFFFFFC, 'h1C0,      0, 'h102);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h0,        'hFFFFFFFC, 0, 'h102);
      add(0, 0, 0, 0,          0, 0,          0, 0,   1, 'h4,        'h0,        0, 'h102);
      add(0, 0, 0, 0,          0, 0,          1, 0,   1, 'h4,        'h0,        0, 'h102);
      add(1, 0, 0, 0,          0, 0,          1, 0,   1, 'h4,        'h0,        0, 'h102);
      add(0, 1, 0, 0,          0, 0,          1, 0,   1, 'h4,        'h0,        0, 'h102);
      add(0, 1, 1, 'h700,      0, 0,          0, 0,   0, 'h8,        'h4,        0, 'h102);
      add(0, 1, 0, 0,          0, 0,          0, 1,   0, 'h8,        'h4,        0, 'h102);
      add(0, 1, 0, 0,          0, 0,          0, 0,   1, 'h8,        'h4,        0, 'h102);
      add(1, 0, 0, 0,          1, 'h1000,     1, 0,   0, 'hC,        'h8,        0, 'h102);
      add(0, 1, 0, 0,          1, 'h2000,     0, 1,   0, 'h1000,     'h8,        0, 'h102);
      add(0, 0, 0, 0,          0, 0,          0, 0,   1, 'h2000,     'h8,        0, 'h102);
      add(0, 1, 0, 0,          0, 0,          1, 0,   1, 'h2000,     'h8,        0, 'h102);
      add(0, 1, 0, 0,          0, 0,          0, 0,   0, 'h2004,     'h2000,     0, 'h102);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i]);
         @(negedge clk);
         chk("valid", i, {31'b0, imem_req_valid}, q[i].ev);
         chk("addr", i, imem_req_addr, q[i].ea);
         chk("pc_current", i, pc_current, q[i].ec);
         chk("pc_next", i, pc_next, q[i].ec + 32'd4);
         chk("misaligned_err", i, {31'b0, misaligned_err}, q[i].ee);
         chk("misaligned_addr", i, misaligned_addr, q[i].em);
         @(posedge clk);
         #1;
      end
      // reset while halted returns to the reset vector and clears the error address
      drive('{default: '0});
      rstn = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("halt_rst_valid", 100, {31'b0, imem_req_valid}, 32'd0);
      chk("halt_rst_addr", 100, imem_req_addr, 32'h80);
      chk("halt_rst_pcc", 100, pc_current, 32'h80);
      chk("halt_rst_maddr", 100, misaligned_addr, 32'h0);
      @(posedge clk);
      #1 imem_req_ready = 1'b0;
      @(negedge clk);
      chk("boot_exit_valid", 101, {31'b0, imem_req_valid}, 32'd1);
      chk("boot_exit_addr", 101, imem_req_addr, 32'h80);
      // reset with a request outstanding abandons it: held is dropped, so stall masks valid
      @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      stall = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("abandon_valid", 102, {31'b0, imem_req_valid}, 32'd0);
      chk("abandon_addr", 102, imem_req_addr, 32'h80);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
